// File: rtl/multiplier_tdm_if.sv
// Frame-level handshake and operand/result buses for the time-multiplexed multiplier.
// The requester drives start and both operand frames; the multiplier returns the result frame and status.
interface multiplier_tdm_if #(
   parameter int BITSIZE  = 16,
   parameter int CHANNELS = 4
);
   logic                         start;
   logic [CHANNELS*BITSIZE-1:0]  in1;
   logic [CHANNELS*BITSIZE-1:0]  in2;
   logic [CHANNELS*BITSIZE-1:0]  out;
   logic                         busy;
   logic                         done;

   modport master (output start, output in1, output in2, input out, input busy, input done);
   modport slave  (input start, input in1, input in2, output out, output busy, output done);
endinterface

// File: rtl/multiplier_tdm.sv
// Multi-channel signed fixed-point multiplier: one shared pipelined multiplier walks a captured
// frame, scales/rounds/saturates each product and publishes the whole frame with a done pulse.
module multiplier_tdm #(
   parameter int BITSIZE  = 16,
   parameter int CHANNELS = 4,
   parameter int FRAC     = BITSIZE - 2,
   parameter int ROUND    = 1,
   parameter int SATURATE = 1
) (
   input  logic             clk,
   input  logic             rst,
   multiplier_tdm_if.slave  bus
);
   localparam int PW = 2 * BITSIZE;
   localparam int W  = PW + 1;
   localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MUL   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic signed [W-1:0] RND_K = (ROUND != 0) ? (W'(1) << (FRAC - 1)) : '0;
   localparam logic signed [W-1:0] SMAX  = {{(BITSIZE + 2){1'b0}}, {(BITSIZE - 1){1'b1}}};
   localparam logic signed [W-1:0] SMIN  = {{(BITSIZE + 2){1'b1}}, {(BITSIZE - 1){1'b0}}};

   generate
      if (CHANNELS < 1 || FRAC < 1 || FRAC > 2 * BITSIZE - 2) begin : g_bad_params
         $error("multiplier_tdm: illegal parameters CHANNELS=%0d FRAC=%0d", CHANNELS, FRAC);
      end
   endgenerate

   logic signed [BITSIZE-1:0]  a_reg [CHANNELS];
   logic signed [BITSIZE-1:0]  b_reg [CHANNELS];
   logic signed [BITSIZE-1:0]  shadow_reg [CHANNELS];
   logic [CHANNELS*BITSIZE-1:0] out_reg;
   logic signed [PW-1:0]       prod_reg;
   logic [IW-1:0]              idx_reg;
   logic [IW-1:0]              pidx_reg;
   logic                       pvalid_reg;
   logic [1:0]                 state_reg;
   logic                       busy_reg;
   logic                       done_reg;

   logic                       accept;
   logic                       last_issue;
   logic                       write_en;
   logic                       publish;
   logic signed [W-1:0]        rounded;
   logic signed [W-1:0]        shifted;
   logic signed [BITSIZE-1:0]  scaled;

   // busy drops as soon as the last channel is issued, so a start seen on the
   // drain edge chains the next frame without a bubble.
   assign accept     = bus.start && !busy_reg;
   assign last_issue = (idx_reg == IW'(CHANNELS - 1));
   assign write_en   = pvalid_reg && (state_reg == S_MUL || state_reg == S_DRAIN);
   assign publish    = (state_reg == S_DRAIN);

   always_comb begin
      rounded = {prod_reg[PW-1], prod_reg} + RND_K;
      shifted = rounded >>> FRAC;
      scaled  = shifted[BITSIZE-1:0];
      if (SATURATE != 0) begin
         if (shifted > SMAX) begin
            scaled = {1'b0, {(BITSIZE - 1){1'b1}}};
         end else if (shifted < SMIN) begin
            scaled = {1'b1, {(BITSIZE - 1){1'b0}}};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         idx_reg    <= '0;
         pidx_reg   <= '0;
         pvalid_reg <= 1'b0;
         prod_reg   <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  state_reg  <= S_MUL;
                  idx_reg    <= '0;
                  busy_reg   <= 1'b1;
                  pvalid_reg <= 1'b0;
               end
            end
            S_MUL: begin
               prod_reg   <= a_reg[idx_reg] * b_reg[idx_reg];
               pidx_reg   <= idx_reg;
               pvalid_reg <= 1'b1;
               if (last_issue) begin
                  idx_reg   <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= S_DRAIN;
               end else begin
                  idx_reg <= idx_reg + IW'(1);
               end
            end
            S_DRAIN: begin
               done_reg   <= 1'b1;
               pvalid_reg <= 1'b0;
               if (accept) begin
                  state_reg <= S_MUL;
                  idx_reg   <= '0;
                  busy_reg  <= 1'b1;
               end else begin
                  state_reg <= S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_reg[gi] <= '0;
               b_reg[gi] <= '0;
            end else if (accept) begin
               a_reg[gi] <= bus.in1[gi*BITSIZE +: BITSIZE];
               b_reg[gi] <= bus.in2[gi*BITSIZE +: BITSIZE];
            end
         end

         // The last channel is still in flight on the publish edge, so it bypasses the shadow.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               shadow_reg[gi]                 <= '0;
               out_reg[gi*BITSIZE +: BITSIZE] <= '0;
            end else begin
               if (write_en && pidx_reg == IW'(gi)) begin
                  shadow_reg[gi] <= scaled;
               end
               if (publish) begin
                  out_reg[gi*BITSIZE +: BITSIZE] <= (pidx_reg == IW'(gi)) ? scaled : shadow_reg[gi];
               end
            end
         end
      end
   endgenerate

   assign bus.out  = out_reg;
   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
endmodule

// File: tb/tb_multiplier_tdm.sv
// Drives a saturating/rounding instance and a legacy (truncate/wrap) instance with the same
// frames and compares every published channel against an arithmetic reference.
module tb_multiplier_tdm;
   localparam int B    = 16;
   localparam int C    = 4;
   localparam int FRAC = 14;
   localparam int FW   = B * C;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   multiplier_tdm_if #(.BITSIZE(B), .CHANNELS(C)) ifa ();
   multiplier_tdm_if #(.BITSIZE(B), .CHANNELS(C)) ifb ();

   multiplier_tdm #(.BITSIZE(B), .CHANNELS(C), .FRAC(FRAC), .ROUND(1), .SATURATE(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa)
   );
   multiplier_tdm #(.BITSIZE(B), .CHANNELS(C), .FRAC(FRAC), .ROUND(0), .SATURATE(0)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [B-1:0] ref_mul(input logic [B-1:0] a, input logic [B-1:0] b,
                                            input bit rnd, input bit sat);
      longint p;
      longint s;
      p = longint'($signed(a)) * longint'($signed(b));
      if (rnd) p = p + (longint'(1) <<< (FRAC - 1));
      s = p >>> FRAC;
      if (sat) begin
         if (s > 32767) s = 32767;
         else if (s < -32768) s = -32768;
      end
      return s[B-1:0];
   endfunction

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [FW-1:0] v1, input logic [FW-1:0] v2);
      ifa.start = s; ifa.in1 = v1; ifa.in2 = v2;
      ifb.start = s; ifb.in1 = v1; ifb.in2 = v2;
   endtask

   function automatic logic [FW-1:0] rnd_frame();
      return {$urandom, $urandom};
   endfunction

   task automatic check_frame(input string tag, input logic [FW-1:0] v1, input logic [FW-1:0] v2);
      logic [B-1:0] a;
      logic [B-1:0] b;
      for (int k = 0; k < C; k++) begin
         a = v1[k*B +: B];
         b = v2[k*B +: B];
         check($sformatf("%s_sat_ch%0d", tag, k), FW'(ifa.out[k*B +: B]), FW'(ref_mul(a, b, 1'b1, 1'b1)));
         check($sformatf("%s_legacy_ch%0d", tag, k), FW'(ifb.out[k*B +: B]), FW'(ref_mul(a, b, 1'b0, 1'b0)));
      end
      $display("frame %s in1=%016h in2=%016h out_sat=%016h out_legacy=%016h", tag, v1, v2, ifa.out, ifb.out);
   endtask

   // Called at posedge+1; returns at posedge+1 one cycle after done.
   task automatic run_frame(input string tag, input logic [FW-1:0] v1, input logic [FW-1:0] v2);
      int n;
      int busy_n;
      bit seen;
      drive(1'b1, v1, v2);
      @(posedge clk); #1;
      drive(1'b0, rnd_frame(), rnd_frame());
      n = 0; busy_n = 0; seen = 0;
      while (!seen && n < 20) begin
         if (ifa.busy === 1'b1) busy_n++;
         @(posedge clk); #1;
         n++;
         if (ifa.done === 1'b1) seen = 1;
      end
      check({tag, "_latency"}, FW'(n), FW'(5));
      check({tag, "_busy_cycles"}, FW'(busy_n), FW'(4));
      check({tag, "_done_b"}, FW'(ifb.done), FW'(1));
      check_frame(tag, v1, v2);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, FW'(ifa.done), FW'(0));
   endtask

   initial begin
      logic [FW-1:0] v1;
      logic [FW-1:0] v2;
      logic [FW-1:0] w1;
      logic [FW-1:0] hv1 [22];
      logic [FW-1:0] hv2 [22];
      logic [FW-1:0] prev_a;
      logic [FW-1:0] prev_b;
      int done_n;
      bit exp_done;

      checks = 0;
      failures = 0;
      rst = 1'b1;
      drive(1'b0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", ifa.out, '0);
      check("reset_busy", FW'(ifa.busy), FW'(0));
      check("reset_done", FW'(ifa.done), FW'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Unity gain, negative unity, positive and negative overflow corners.
      v1 = {16'h8000, 16'h7FFF, 16'hC000, 16'h4000};
      v2 = {16'h8000, 16'h7FFF, 16'h1234, 16'h1234};
      run_frame("directed_gain", v1, v2);
      check("gain_ch0", FW'(ifa.out[15:0]), FW'(16'h1234));
      check("gain_ch1", FW'(ifa.out[31:16]), FW'(16'hEDCC));
      check("sat_pos", FW'(ifa.out[47:32]), FW'(16'h7FFF));
      check("sat_neg_sq", FW'(ifa.out[63:48]), FW'(16'h7FFF));
      check("wrap_pos", FW'(ifb.out[47:32]), FW'(16'hFFFC));
      check("wrap_neg_sq", FW'(ifb.out[63:48]), FW'(16'h0000));

      // Rounding half-way cases.
      v1 = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
      v2 = {16'h7FFF, 16'h8000, 16'h2000, 16'h2000};
      run_frame("directed_round", v1, v2);
      check("round_up", FW'(ifa.out[15:0]), FW'(16'h0001));
      check("trunc_up", FW'(ifb.out[15:0]), FW'(16'h0000));
      check("round_neg", FW'(ifa.out[31:16]), FW'(16'h0000));
      check("trunc_neg", FW'(ifb.out[31:16]), FW'(16'hFFFF));

      for (int i = 0; i < 200; i++) begin
         run_frame($sformatf("rand%0d", i), rnd_frame(), rnd_frame());
      end

      // Start held high: a frame every 5 cycles, out moves only on done.
      for (int i = 0; i < 22; i++) begin
         hv1[i] = rnd_frame();
         hv2[i] = rnd_frame();
      end
      drive(1'b1, hv1[0], hv2[0]);
      prev_a = ifa.out;
      prev_b = ifb.out;
      for (int c = 0; c < 22; c++) begin
         @(posedge clk); #1;
         exp_done = (c > 0) && (c % 5 == 0);
         check($sformatf("held_done_c%0d", c), FW'(ifa.done), FW'(exp_done));
         check($sformatf("held_done_b_c%0d", c), FW'(ifb.done), FW'(exp_done));
         if (exp_done) begin
            check_frame($sformatf("held_c%0d", c), hv1[c-5], hv2[c-5]);
         end else begin
            check($sformatf("held_stable_a_c%0d", c), ifa.out, prev_a);
            check($sformatf("held_stable_b_c%0d", c), ifb.out, prev_b);
         end
         prev_a = ifa.out;
         prev_b = ifb.out;
         if (c < 21) drive((c + 1) <= 15, hv1[c+1], hv2[c+1]);
      end
      drive(1'b0, '0, '0);
      @(posedge clk); #1;

      // Starts pulsed while busy are ignored and do not disturb the latched operands.
      v1 = rnd_frame(); v2 = rnd_frame(); w1 = ~v1;
      drive(1'b1, v1, v2);
      @(posedge clk); #1;          // E0
      drive(1'b0, w1, w1);
      @(posedge clk); #1;          // E1
      drive(1'b1, w1, w1);
      @(posedge clk); #1;          // E2 sees start while busy
      drive(1'b0, w1, w1);
      @(posedge clk); #1;          // E3
      drive(1'b1, w1, w1);
      @(posedge clk); #1;          // E4 sees start while busy
      drive(1'b0, w1, w1);
      @(posedge clk); #1;          // E5
      check("ignore_done", FW'(ifa.done), FW'(1));
      check_frame("ignore_frame", v1, v2);
      done_n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ifa.done === 1'b1 || ifb.done === 1'b1) done_n++;
      end
      check("ignore_no_extra_done", FW'(done_n), FW'(0));

      // Reset mid-frame aborts immediately and suppresses done.
      drive(1'b1, rnd_frame(), rnd_frame());
      @(posedge clk); #1;
      drive(1'b0, '0, '0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_out", ifa.out, '0);
      check("midrst_out_b", ifb.out, '0);
      check("midrst_busy", FW'(ifa.busy), FW'(0));
      check("midrst_done", FW'(ifa.done), FW'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      done_n = 0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         if (ifa.done === 1'b1 || ifb.done === 1'b1) done_n++;
      end
      check("midrst_no_done", FW'(done_n), FW'(0));
      check("midrst_out_held", ifa.out, '0);
      run_frame("after_rst", rnd_frame(), rnd_frame());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
